// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory loader.
//   imem_state_e : controller states (CLEAR, IDLE, LOAD)
//   NOP          : word written to every location while clearing (all zeros)
//   ea_width()   : width of the fetch effective-address arithmetic; one bit
//                  wider than offset + bank terms so the sum never wraps
package imem_pkg;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      LOAD  = 2'd2
   } imem_state_e;

   localparam int unsigned NOP = 0;

   function automatic int ea_width(input int addr_w, input int bank_w);
      return addr_w + bank_w + 1;
   endfunction

endpackage

// File: rtl/imem_sdp_ram.sv
// Simple dual-port word store: one write port, one registered read port.
//   i_clock, i_reset_n : clock, synchronous active-low reset (read register only)
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr         : read request; o_rdata updates on the next edge and
//                          holds between reads
//   i_rclr               : with i_re, loads zero instead of a stored word (used
//                          for out-of-range fetches)
module imem_sdp_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 128,
   parameter int AW    = 7
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic             i_rclr,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge i_clock) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= i_rclr ? '0 : r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/instruction_memory_loader.sv
// Banked instruction store for the fetch stage, loaded at run time.
// After reset every word is cleared to NOP, then programs are streamed in via
// the load handshake and fetched per bank with a one-cycle registered read.
//   i_clock, i_reset_n       : clock, synchronous active-low reset
//   i_load_start/i_load_addr : open a load at a word index (IDLE only)
//   i_load_valid/i_load_last/i_load_data : load stream; o_load_ready high in LOAD
//   o_load_done              : pulse after the terminating load write
//   i_fetch_req/i_fetch_addr/i_bank_sel : fetch (IDLE only), offset within bank
//   o_instr/o_instr_valid    : fetched word (holds) and its one-cycle strobe
//   o_addr_err               : pulse for an out-of-range fetch or load
//   o_busy                   : high while clearing or loading
//   o_parity_err             : only when IMEM_PARITY_EN is defined; pulses with
//                              o_instr_valid if the stored even parity mismatches
//
// State table
//   state | meaning
//   CLEAR | writing NOP to word r_clr_cnt, one word per cycle
//   IDLE  | serving fetches, accepting load_start
//   LOAD  | writing streamed words at r_wptr
module instruction_memory_loader
   import imem_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 10,
   parameter int DEPTH      = 128,
   parameter int BANK_WORDS = 16,
   parameter int BANK_W     = 2
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_load_start,
   input  logic [ADDR_W-1:0] i_load_addr,
   input  logic              i_load_valid,
   input  logic              i_load_last,
   input  logic [DATA_W-1:0] i_load_data,
   output logic              o_load_ready,
   output logic              o_load_done,
   input  logic              i_fetch_req,
   input  logic [ADDR_W-1:0] i_fetch_addr,
   input  logic [BANK_W-1:0] i_bank_sel,
   output logic [DATA_W-1:0] o_instr,
   output logic              o_instr_valid,
   output logic              o_addr_err,
`ifdef IMEM_PARITY_EN
   output logic              o_parity_err,
`endif
   output logic              o_busy
);

   localparam int EA_W   = ea_width(ADDR_W, BANK_W);
   localparam int RAM_AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
   localparam int WORD_W = DATA_W + 1;
`else
   localparam int WORD_W = DATA_W;
`endif
   localparam logic [EA_W-1:0]   DEPTH_EA  = EA_W'(DEPTH);
   localparam logic [RAM_AW-1:0] LAST_WORD = RAM_AW'(DEPTH - 1);

   imem_state_e       r_state;
   logic [RAM_AW-1:0] r_clr_cnt;
   logic [RAM_AW-1:0] r_wptr;
   logic              r_instr_valid;
   logic              r_fetch_oor;
   logic              r_load_ready;
   logic              r_load_done;
   logic              r_addr_err;
   logic              r_busy;

   logic [EA_W-1:0]   w_ea;
   logic              w_fetch_in_range;
   logic              w_load_in_range;
   logic              w_fetch;
   logic              w_we;
   logic [RAM_AW-1:0] w_waddr;
   logic [WORD_W-1:0] w_wdata;
   logic [WORD_W-1:0] w_load_word;
   logic [WORD_W-1:0] w_rdata;

   // Effective address is formed wide enough that a large offset in a high
   // bank is reported as out of range instead of aliasing into low memory.
   assign w_ea             = EA_W'(i_fetch_addr) + EA_W'(i_bank_sel) * EA_W'(BANK_WORDS);
   assign w_fetch_in_range = (w_ea < DEPTH_EA);
   assign w_load_in_range  = (EA_W'(i_load_addr) < DEPTH_EA);
   assign w_fetch          = i_reset_n && (r_state == IDLE) && i_fetch_req;

`ifdef IMEM_PARITY_EN
   assign w_load_word = {^i_load_data, i_load_data};
`else
   assign w_load_word = i_load_data;
`endif

   assign w_we    = i_reset_n && ((r_state == CLEAR) || ((r_state == LOAD) && i_load_valid));
   assign w_waddr = (r_state == CLEAR) ? r_clr_cnt : r_wptr;
   assign w_wdata = (r_state == CLEAR) ? WORD_W'(NOP) : w_load_word;

   imem_sdp_ram #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH),
      .AW    (RAM_AW)
   ) u_ram (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_we      (w_we),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_re      (w_fetch),
      .i_rclr    (!w_fetch_in_range),
      .i_raddr   (w_ea[RAM_AW-1:0]),
      .o_rdata   (w_rdata)
   );

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state       <= CLEAR;
         r_clr_cnt     <= '0;
         r_wptr        <= '0;
         r_instr_valid <= 1'b0;
         r_fetch_oor   <= 1'b0;
         r_load_ready  <= 1'b0;
         r_load_done   <= 1'b0;
         r_addr_err    <= 1'b0;
         r_busy        <= 1'b1;
      end else begin
         r_instr_valid <= 1'b0;
         r_fetch_oor   <= 1'b0;
         r_load_done   <= 1'b0;
         r_addr_err    <= 1'b0;
         case (r_state)
            CLEAR: begin
               r_clr_cnt <= r_clr_cnt + RAM_AW'(1);
               if (r_clr_cnt == LAST_WORD) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            IDLE: begin
               if (i_fetch_req) begin
                  r_instr_valid <= 1'b1;
                  r_fetch_oor   <= !w_fetch_in_range;
                  if (!w_fetch_in_range) begin
                     r_addr_err <= 1'b1;
                  end
               end
               if (i_load_start) begin
                  if (w_load_in_range) begin
                     r_state      <= LOAD;
                     r_wptr       <= i_load_addr[RAM_AW-1:0];
                     r_load_ready <= 1'b1;
                     r_busy       <= 1'b1;
                  end else begin
                     r_addr_err <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (i_load_valid) begin
                  r_wptr <= r_wptr + RAM_AW'(1);
                  // The top word ends the load even without load_last so the
                  // pointer never wraps onto word 0.
                  if (i_load_last || (r_wptr == LAST_WORD)) begin
                     r_state      <= IDLE;
                     r_load_ready <= 1'b0;
                     r_busy       <= 1'b0;
                     r_load_done  <= 1'b1;
                     if (!i_load_last) begin
                        r_addr_err <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               r_state      <= CLEAR;
               r_clr_cnt    <= '0;
               r_load_ready <= 1'b0;
               r_busy       <= 1'b1;
            end
         endcase
      end
   end

   assign o_instr       = w_rdata[DATA_W-1:0];
   assign o_instr_valid = r_instr_valid;
   assign o_load_ready  = r_load_ready;
   assign o_load_done   = r_load_done;
   assign o_addr_err    = r_addr_err;
   assign o_busy        = r_busy;

`ifdef IMEM_PARITY_EN
   assign o_parity_err = r_instr_valid && !r_fetch_oor &&
                         ((^w_rdata[DATA_W-1:0]) != w_rdata[DATA_W]);
`endif

endmodule
